// File: rtl/i16_biquad.sv
// ---------------------------------------------------------------------------
// i16_biquad
//   One 16-bit signed fixed-point second-order IIR section (Direct Form I).
//   Coefficients are Q2.14 run-time inputs, and the feedback terms are
//   pre-negated, so every term is added. One sample is processed per clock,
//   there is no handshake, and the output is registered (latency 1 cycle).
//
//   acc = b_0*A + b_1*x1 + b_2*x2 + a_1*y1 + a_2*y2
//   y   = sat16(acc >>> FRAC_BITS)
//
// Ports
//   CLK  in   1   clock, rising-edge active
//   RST  in   1   asynchronous active-high reset (clears history and B)
//   A    in   16  signed input sample x[n]
//   b_0  in   16  Q2.14 feed-forward coefficient for x[n]
//   b_1  in   16  Q2.14 feed-forward coefficient for x[n-1]
//   b_2  in   16  Q2.14 feed-forward coefficient for x[n-2]
//   a_1  in   16  Q2.14 feedback coefficient for y[n-1] (pre-negated)
//   a_2  in   16  Q2.14 feedback coefficient for y[n-2] (pre-negated)
//   B    out  16  signed output sample y[n], registered
//
// Configuration macro
//   I16_BIQUAD_ROUND_EN : when defined, 2**(FRAC_BITS-1) is added before the
//                         shift (round half up); otherwise the shift floors.
// ---------------------------------------------------------------------------
module i16_biquad #(
    parameter int FRAC_BITS = 14,
    parameter int ACC_W     = 36
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic signed [15:0] A,
    input  logic signed [15:0] b_0,
    input  logic signed [15:0] b_1,
    input  logic signed [15:0] b_2,
    input  logic signed [15:0] a_1,
    input  logic signed [15:0] a_2,
    output logic signed [15:0] B
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);
`ifdef I16_BIQUAD_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND_OFS = ACC_W'(64'sd1 <<< (FRAC_BITS - 1));
`else
    localparam logic signed [ACC_W-1:0] RND_OFS = ACC_W'(64'sd0);
`endif

    // Sample history (x) and saturated-output history (y)
    logic signed [15:0] x1_r, x2_r, y1_r, y2_r;

    // Operands widened to 32 bits so each product is the full exact product
    logic signed [31:0] p0_s, p1_s, p2_s, p3_s, p4_s;
    logic signed [ACC_W-1:0] acc_s, acc_rnd_s, shifted_s;
    logic signed [15:0] y_s;

    assign p0_s = 32'(A)    * 32'(b_0);
    assign p1_s = 32'(x1_r) * 32'(b_1);
    assign p2_s = 32'(x2_r) * 32'(b_2);
    assign p3_s = 32'(y1_r) * 32'(a_1);
    assign p4_s = 32'(y2_r) * 32'(a_2);

    // Exact accumulation of the five products, optional rounding offset, floor shift
    always_comb begin
        acc_s     = ACC_W'(p0_s) + ACC_W'(p1_s) + ACC_W'(p2_s)
                  + ACC_W'(p3_s) + ACC_W'(p4_s);
        acc_rnd_s = acc_s + RND_OFS;
        shifted_s = acc_rnd_s >>> FRAC_BITS;
    end

    // Clamp the shifted sum to the 16-bit signed range (no wrap-around)
    always_comb begin
        y_s = 16'sd0;
        if (shifted_s > SAT_MAX) begin
            y_s = 16'sh7FFF;
        end else if (shifted_s < SAT_MIN) begin
            y_s = 16'sh8000;
        end else begin
            y_s = shifted_s[15:0];
        end
    end

    // History shift and registered output; feedback is taken from the saturated y
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x1_r <= 16'sd0;
            x2_r <= 16'sd0;
            y1_r <= 16'sd0;
            y2_r <= 16'sd0;
            B    <= 16'sd0;
        end else begin
            x2_r <= x1_r;
            x1_r <= A;
            y2_r <= y1_r;
            y1_r <= y_s;
            B    <= y_s;
        end
    end

endmodule

// File: tb/tb_i16_biquad.sv
// ---------------------------------------------------------------------------
// tb_i16_biquad
//   Directed-vector bench with a scoreboard. The stimulus process drives A at
//   the falling edge and pushes the hand-computed expected B for the next
//   rising edge; a monitor pops and compares 1 time unit after every rising
//   edge. Build with +define+I16_BIQUAD_ROUND_EN to exercise rounding.
// ---------------------------------------------------------------------------
module tb_i16_biquad;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic signed [15:0] A   = 16'sd0;
    logic signed [15:0] b_0 = 16'sd0;
    logic signed [15:0] b_1 = 16'sd0;
    logic signed [15:0] b_2 = 16'sd0;
    logic signed [15:0] a_1 = 16'sd0;
    logic signed [15:0] a_2 = 16'sd0;
    logic signed [15:0] B;

    typedef struct {
        string              name;
        logic signed [15:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    i16_biquad #(.FRAC_BITS(14), .ACC_W(36)) dut (
        .CLK(CLK), .RST(RST), .A(A),
        .b_0(b_0), .b_1(b_1), .b_2(b_2), .a_1(a_1), .a_2(a_2),
        .B(B)
    );

    always #5 CLK = ~CLK;

    // Watchdog: the run must never hang
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Monitor: compare B against the scoreboard after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (B !== e.value) begin
                    bad++;
                    $display("FAIL %s: got=%0d expected=%0d", e.name, B, e.value);
                end
            end
        end
    end

    task automatic check_now(input string nm, input logic signed [15:0] expv);
        total++;
        if (B !== expv) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, B, expv);
        end
    endtask

    // Drive one sample at the falling edge; optionally queue its expected output
    task automatic step(input logic signed [15:0] a_in, input bit chk,
                        input logic signed [15:0] expv, input string nm);
        exp_t e;
        @(negedge CLK);
        A = a_in;
        if (chk) begin
            e.name  = nm;
            e.value = expv;
            exp_q.push_back(e);
        end
    endtask

    // Short reset pulse between rising edges; clears history and coefficients
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        A   = 16'sd0;
        b_0 = 16'sd0; b_1 = 16'sd0; b_2 = 16'sd0; a_1 = 16'sd0; a_2 = 16'sd0;
        #2;
        RST = 1'b0;
    endtask

    initial begin
        logic signed [15:0] rnd_neg, rnd_pos;
        int wait_cnt;
`ifdef I16_BIQUAD_ROUND_EN
        rnd_neg = 16'sd0;
        rnd_pos = 16'sd1;
`else
        rnd_neg = -16'sd1;
        rnd_pos = 16'sd0;
`endif
        // Reset state
        #3;
        check_now("reset_B", 16'sd0);
        @(negedge CLK);
        RST = 1'b0;

        // Pass-through
        do_reset();
        b_0 = 16'sd16384;
        step(16'sd16384, 1'b1, 16'sd16384, "pass_1");
        step(16'sd0,     1'b1, 16'sd0,     "pass_2");

        // Pure two-sample delay through b_2
        do_reset();
        b_2 = 16'sd16384;
        step(16'sd1000, 1'b1, 16'sd0,    "delay2_0");
        step(16'sd0,    1'b1, 16'sd0,    "delay2_1");
        step(16'sd0,    1'b1, 16'sd1000, "delay2_2");
        step(16'sd0,    1'b1, 16'sd0,    "delay2_3");

        // One-sample delay through b_1
        do_reset();
        b_1 = 16'sd16384;
        step(16'sd1000, 1'b1, 16'sd0,    "delay1_0");
        step(16'sd0,    1'b1, 16'sd1000, "delay1_1");
        step(16'sd0,    1'b1, 16'sd0,    "delay1_2");

        // Second-order feedback through a_2 = -0.5: 1000, 0, -500, 0, 250
        do_reset();
        b_0 = 16'sd16384;
        a_2 = -16'sd8192;
        step(16'sd1000, 1'b1, 16'sd1000,  "fb2_0");
        step(16'sd0,    1'b1, 16'sd0,     "fb2_1");
        step(16'sd0,    1'b1, -16'sd500,  "fb2_2");
        step(16'sd0,    1'b1, 16'sd0,     "fb2_3");
        step(16'sd0,    1'b1, 16'sd250,   "fb2_4");

        // Integrator with positive saturation
        do_reset();
        b_0 = 16'sd16384;
        a_1 = 16'sd16384;
        step(16'sd10000, 1'b1, 16'sd10000, "integ_0");
        step(16'sd10000, 1'b1, 16'sd20000, "integ_1");
        step(16'sd10000, 1'b1, 16'sd30000, "integ_2");
        step(16'sd10000, 1'b1, 16'sd32767, "integ_sat_3");
        step(16'sd10000, 1'b1, 16'sd32767, "integ_sat_4");

        // Integrator with negative saturation
        do_reset();
        b_0 = 16'sd16384;
        a_1 = 16'sd16384;
        step(-16'sd20000, 1'b1, -16'sd20000, "neg_0");
        step(-16'sd20000, 1'b1, -16'sd32768, "neg_sat_1");
        step(-16'sd20000, 1'b1, -16'sd32768, "neg_sat_2");

        // Rounding / truncation of half-LSB results
        do_reset();
        b_0 = 16'sd8192;
        step(-16'sd1, 1'b1, rnd_neg, "round_neg");
        step(16'sd1,  1'b1, rnd_pos, "round_pos");

        // Asynchronous reset mid-stream clears history
        do_reset();
        b_0 = 16'sd16384;
        a_1 = 16'sd16384;
        step(16'sd10000, 1'b1, 16'sd10000, "mid_0");
        step(16'sd10000, 1'b1, 16'sd20000, "mid_1");
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_now("async_rst_B", 16'sd0);
        #1;
        RST = 1'b0;
        A = 16'sd5000;
        begin
            exp_t e;
            e.name = "post_rst_0"; e.value = 16'sd5000;
            exp_q.push_back(e);
        end
        step(16'sd5000, 1'b1, 16'sd10000, "post_rst_1");

        // Drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge CLK);
            wait_cnt++;
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending expected=0 pending", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
